// File: rtl/torque_scheduler_if.sv
// Handshake and data bundle between the physics-step controller and torque_scheduler.
// The controller drives through the master modport and the torque engine uses the
// slave modport.
interface torque_scheduler_if #(
    parameter int NUM_NODES     = 10,
    parameter int POSITION_SIZE = 8,
    parameter int FORCE_SIZE    = 8
);
    logic                                                begin_in;
    logic signed [2:0]                                   drive;
    logic [1:0][NUM_NODES-1:0][POSITION_SIZE-1:0]        nodes;
    logic [1:0][POSITION_SIZE-1:0]                       axle;
    logic [1:0][NUM_NODES-1:0][FORCE_SIZE-1:0]           torque_forces;
    logic                                                busy_out;
    logic                                                result_out;

    modport master (
        output begin_in, drive, nodes, axle,
        input  torque_forces, busy_out, result_out
    );

    modport slave (
        input  begin_in, drive, nodes, axle,
        output torque_forces, busy_out, result_out
    );
endinterface

// File: rtl/torque_scheduler.sv
// Time-multiplexed torque engine for the wheel soft-body.
// It handles one node per cycle through a two-stage pipeline. Stage 1 forms the
// node-to-axle differences. Stage 2 multiplies them by the latched drive and the
// constant gain, then writes one entry of the registered force buffer.
// Build option: define TORQUE_SATURATE_EN to clamp each force component to the
// FORCE_SIZE signed range. When it is not defined, each component wraps to its low
// FORCE_SIZE bits, which matches the legacy combinational torque stage.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for begin_in; buffer holds the last results
// S_RUN    | issuing nodes into stage 1 and retiring them from stage 2
module torque_scheduler #(
    parameter int NUM_NODES     = 10,
    parameter int POSITION_SIZE = 8,
    parameter int FORCE_SIZE    = 8,
    parameter int TORQUE        = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    torque_scheduler_if.slave  bus
);
    localparam int DW = POSITION_SIZE + 1;
    localparam int PW = POSITION_SIZE + 1 + 3 + $clog2(TORQUE) + 1;
    localparam int IW = (NUM_NODES > 1) ? $clog2(NUM_NODES + 1) : 1;

    localparam logic [IW-1:0]        NODE_CNT = IW'(NUM_NODES);
    localparam logic [IW-1:0]        LAST_IDX = IW'(NUM_NODES - 1);
    localparam logic signed [PW-1:0] TORQUE_S = PW'(TORQUE);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]                     state_q, state_d;
    logic [IW-1:0]                  idx_q, idx_d;
    logic [IW-1:0]                  idx1_q, idx1_d;
    logic                           valid1_q, valid1_d;
    logic                           busy_q, busy_d;
    logic                           result_q, result_d;
    logic signed [2:0]              drive_q, drive_d;
    logic signed [POSITION_SIZE-1:0] axle_x_q, axle_x_d;
    logic signed [POSITION_SIZE-1:0] axle_y_q, axle_y_d;
    logic signed [DW-1:0]           dx_q, dx_d;
    logic signed [DW-1:0]           dy_q, dy_d;
    logic [1:0][NUM_NODES-1:0][FORCE_SIZE-1:0] forces_q, forces_d;

    logic signed [POSITION_SIZE-1:0] node_x, node_y;
    logic signed [PW-1:0]           prod_0, prod_1;
    logic [FORCE_SIZE-1:0]          force_0, force_1;

    // Select the node addressed by the issue pointer from the live node bus.
    always_comb begin
        node_x = '0;
        node_y = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            if (idx_q == IW'(i)) begin
                node_x = bus.nodes[0][i];
                node_y = bus.nodes[1][i];
            end
        end
    end

    // Full-precision products on the shared multiply path. Component 0 uses dy and
    // component 1 uses dx, which gives the force perpendicular to the radius.
    always_comb begin
        prod_0 = PW'(dy_q) * PW'(drive_q) * TORQUE_S;
        prod_1 = PW'(dx_q) * PW'(drive_q) * TORQUE_S;
    end

`ifdef TORQUE_SATURATE_EN
    localparam logic signed [PW-1:0] F_MAX = PW'((2 ** (FORCE_SIZE - 1)) - 1);
    localparam logic signed [PW-1:0] F_MIN = PW'(-(2 ** (FORCE_SIZE - 1)));

    // Clamp each product into the signed FORCE_SIZE range.
    always_comb begin
        if (prod_0 > F_MAX)      force_0 = F_MAX[FORCE_SIZE-1:0];
        else if (prod_0 < F_MIN) force_0 = F_MIN[FORCE_SIZE-1:0];
        else                     force_0 = prod_0[FORCE_SIZE-1:0];
        if (prod_1 > F_MAX)      force_1 = F_MAX[FORCE_SIZE-1:0];
        else if (prod_1 < F_MIN) force_1 = F_MIN[FORCE_SIZE-1:0];
        else                     force_1 = prod_1[FORCE_SIZE-1:0];
    end
`else
    logic unused_prod_hi;

    // Two's-complement wrap: keep only the low FORCE_SIZE bits.
    always_comb begin
        force_0 = prod_0[FORCE_SIZE-1:0];
        force_1 = prod_1[FORCE_SIZE-1:0];
    end

    assign unused_prod_hi = ^{prod_0[PW-1:FORCE_SIZE], prod_1[PW-1:FORCE_SIZE]};
`endif

    // Sequencing: start handshake, stage-1 issue, stage-2 write-back and completion.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        idx1_d   = idx1_q;
        valid1_d = 1'b0;
        busy_d   = busy_q;
        result_d = 1'b0;
        drive_d  = drive_q;
        axle_x_d = axle_x_q;
        axle_y_d = axle_y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        forces_d = forces_q;

        case (state_q)
            S_IDLE: begin
                if (bus.begin_in) begin
                    state_d  = S_RUN;
                    busy_d   = 1'b1;
                    idx_d    = '0;
                    drive_d  = bus.drive;
                    axle_x_d = bus.axle[0];
                    axle_y_d = bus.axle[1];
                end
            end
            S_RUN: begin
                if (idx_q < NODE_CNT) begin
                    dx_d     = DW'(node_x) - DW'(axle_x_q);
                    dy_d     = DW'(axle_y_q) - DW'(node_y);
                    valid1_d = 1'b1;
                    idx1_d   = idx_q;
                    idx_d    = idx_q + 1'b1;
                end
                if (valid1_q) begin
                    for (int i = 0; i < NUM_NODES; i++) begin
                        if (idx1_q == IW'(i)) begin
                            forces_d[0][i] = force_0;
                            forces_d[1][i] = force_1;
                        end
                    end
                    if (idx1_q == LAST_IDX) begin
                        state_d  = S_IDLE;
                        busy_d   = 1'b0;
                        result_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset. A reset during a run also clears the buffer.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            idx1_q   <= '0;
            valid1_q <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= 1'b0;
            drive_q  <= '0;
            axle_x_q <= '0;
            axle_y_q <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            forces_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            idx1_q   <= idx1_d;
            valid1_q <= valid1_d;
            busy_q   <= busy_d;
            result_q <= result_d;
            drive_q  <= drive_d;
            axle_x_q <= axle_x_d;
            axle_y_q <= axle_y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            forces_q <= forces_d;
        end
    end

    assign bus.torque_forces = forces_q;
    assign bus.busy_out      = busy_q;
    assign bus.result_out    = result_q;
endmodule

// File: tb/tb_torque_scheduler.sv
// Self-checking bench for torque_scheduler with NUM_NODES=4.
// The reference model computes each force directly from the node, axle and drive values
// using integer arithmetic. The bench tracks the buffer contents it expects at every edge.
module tb_torque_scheduler;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    torque_scheduler_if #(.NUM_NODES(N), .POSITION_SIZE(8), .FORCE_SIZE(8)) bus ();

    torque_scheduler #(.NUM_NODES(N), .POSITION_SIZE(8), .FORCE_SIZE(8), .TORQUE(4)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    int stim_nx [N];
    int stim_ny [N];
    int stim_ax, stim_ay, stim_drv;
    int cur [2][N];

    function automatic int reduce(int v);
        logic [7:0] t;
`ifdef TORQUE_SATURATE_EN
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
`else
        t = v[7:0];
        return int'($signed(t));
`endif
    endfunction

    function automatic int model_force(int comp, int k);
        if (comp == 0) return reduce((stim_ay - stim_ny[k]) * stim_drv * 4);
        return reduce((stim_nx[k] - stim_ax) * stim_drv * 4);
    endfunction

    task automatic random_stim();
        for (int k = 0; k < N; k++) begin
            stim_nx[k] = int'($urandom_range(0, 255)) - 128;
            stim_ny[k] = int'($urandom_range(0, 255)) - 128;
        end
        stim_ax  = int'($urandom_range(0, 255)) - 128;
        stim_ay  = int'($urandom_range(0, 255)) - 128;
        stim_drv = int'($urandom_range(0, 7)) - 4;
    endtask

    task automatic apply_stim();
        for (int k = 0; k < N; k++) begin
            bus.nodes[0][k] = 8'(stim_nx[k]);
            bus.nodes[1][k] = 8'(stim_ny[k]);
        end
        bus.axle[0] = 8'(stim_ax);
        bus.axle[1] = 8'(stim_ay);
        bus.drive   = 3'(stim_drv);
    endtask

    task automatic check_buffer(string tag);
        logic signed [7:0] got;
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < N; k++) begin
                got = bus.torque_forces[c][k];
                checks++;
                if (got !== 8'(cur[c][k])) begin
                    errors++;
                    $display("FAIL %s force[%0d][%0d] got %0d expected %0d at %0t",
                             tag, c, k, got, cur[c][k], $time);
                end
            end
        end
    endtask

    // Runs one complete job and checks busy, result and the buffer on every edge E0..E(N+1).
    // If prestarted is set, begin_in is already high and the next edge is E0.
    task automatic run_check(string tag, input bit prestarted, input int repulse_at,
                             input bit hold_after);
        if (!prestarted) begin
            @(negedge clk);
            apply_stim();
            bus.begin_in = 1'b1;
        end
        @(posedge clk); #1;
        checks++;
        if (bus.busy_out !== 1'b1 || bus.result_out !== 1'b0) begin
            errors++;
            $display("FAIL %s start busy=%b result=%b expected busy=1 result=0",
                     tag, bus.busy_out, bus.result_out);
        end
        bus.begin_in = (repulse_at == 1);
        for (int e = 1; e <= N + 1; e++) begin
            @(posedge clk); #1;
            if (e >= 2) begin
                cur[0][e-2] = model_force(0, e - 2);
                cur[1][e-2] = model_force(1, e - 2);
            end
            check_buffer(tag);
            checks++;
            if (bus.result_out !== (e == N + 1) || bus.busy_out !== (e < N + 1)) begin
                errors++;
                $display("FAIL %s E%0d result=%b busy=%b expected result=%b busy=%b",
                         tag, e, bus.result_out, bus.busy_out, (e == N + 1), (e < N + 1));
            end
            bus.begin_in = (e + 1 == repulse_at);
        end
        if (hold_after) begin
            random_stim();
            apply_stim();
            bus.begin_in = 1'b1;
        end else begin
            @(posedge clk); #1;
            checks++;
            if (bus.result_out !== 1'b0 || bus.busy_out !== 1'b0) begin
                errors++;
                $display("FAIL %s after-done result=%b busy=%b expected 0 0",
                         tag, bus.result_out, bus.busy_out);
            end
        end
    endtask

    task automatic check_const(string tag, int c, int k, int expv);
        logic signed [7:0] got;
        got = bus.torque_forces[c][k];
        checks++;
        if (got !== 8'(expv)) begin
            errors++;
            $display("FAIL %s force[%0d][%0d] got %0d required %0d", tag, c, k, got, expv);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.begin_in = 1'b0;
        for (int k = 0; k < N; k++) begin
            stim_nx[k] = 0; stim_ny[k] = 0;
        end
        stim_ax = 0; stim_ay = 0; stim_drv = 0;
        apply_stim();
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < N; k++) cur[c][k] = 0;
        check_buffer("reset");
        checks++;
        if (bus.busy_out !== 1'b0 || bus.result_out !== 1'b0) begin
            errors++;
            $display("FAIL reset busy=%b result=%b expected 0 0", bus.busy_out, bus.result_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        random_stim();
        stim_ax = 0; stim_ay = 0;
        stim_nx[0] = 10; stim_ny[0] = 5;
        stim_drv = 1;
        run_check("basic", 1'b0, -1, 1'b0);
        check_const("basic_f0", 0, 0, -20);
        check_const("basic_f1", 1, 0, 40);
    endtask

    task automatic test_offset_axle();
        random_stim();
        stim_ax = 2; stim_ay = -3;
        stim_nx[2] = -6; stim_ny[2] = 7;
        stim_drv = -2;
        run_check("offset", 1'b0, -1, 1'b0);
        check_const("offset_f0", 0, 2, 80);
        check_const("offset_f1", 1, 2, 64);
    endtask

    task automatic test_overflow();
        random_stim();
        stim_ax = 0; stim_ay = 0;
        stim_nx[0] = 100; stim_ny[0] = 0;
        stim_drv = 3;
        run_check("overflow", 1'b0, -1, 1'b0);
`ifdef TORQUE_SATURATE_EN
        check_const("overflow_f1", 1, 0, 127);
`else
        check_const("overflow_f1", 1, 0, -80);
`endif
        check_const("overflow_f0", 0, 0, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            random_stim();
            if (r == 0) stim_drv = 0;
            if (r == 1) stim_drv = -4;
            if (r == 2) begin
                stim_drv = -4; stim_ax = 127; stim_ay = -128;
                for (int k = 0; k < N; k++) begin
                    stim_nx[k] = -128; stim_ny[k] = 127;
                end
            end
            run_check("random", 1'b0, -1, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        random_stim();
        run_check("b2b_first", 1'b0, 2, 1'b1);
        run_check("b2b_second", 1'b1, -1, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        random_stim();
        stim_drv = 3;
        @(negedge clk);
        apply_stim();
        bus.begin_in = 1'b1;
        @(posedge clk); #1;
        bus.begin_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < N; k++) cur[c][k] = 0;
        check_buffer("midreset");
        checks++;
        if (bus.busy_out !== 1'b0 || bus.result_out !== 1'b0) begin
            errors++;
            $display("FAIL midreset busy=%b result=%b expected 0 0",
                     bus.busy_out, bus.result_out);
        end
        for (int e = 0; e < 6; e++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.result_out !== 1'b0 || bus.busy_out !== 1'b0) begin
                errors++;
                $display("FAIL midreset_quiet result=%b busy=%b expected 0 0",
                         bus.result_out, bus.busy_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_offset_axle();
        test_overflow();
        test_random();
        test_back_to_back();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
